// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES-128 inverse cipher.
//   - fsm_e            : controller states (IDLE, KEYEXP, DEC)
//   - NR               : number of rounds (AES-128 only)
//   - rcon / rot_word  : key-schedule helpers
//   - xtime / gf_mul   : GF(2^8) arithmetic, polynomial 0x11b
//   - inv_shift_rows / inv_mix_columns : state transforms
// State byte k sits at bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
package aes_dec_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    DEC    = 2'd2
  } fsm_e;

  // Round constant, MSB byte of the Rcon word; index 0 and >10 give 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Row r rotates right by r: out[row][c] = in[row][(c - row) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox_dual.sv
// AES S-box usable in either direction, built from the GF(2^8) inverse
// and the affine transform rather than a lookup table.
//   inv : 0 = forward SubBytes, 1 = InvSubBytes (tie off per instance)
//   a   : input byte
//   y   : substituted byte
module aes_sbox_dual
  import aes_dec_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // x^254 == x^-1 in GF(2^8); 0 maps to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] v);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] v);
    return rotl8(v, 1) ^ rotl8(v, 3) ^ rotl8(v, 6) ^ 8'h05;
  endfunction

  assign y = inv ? gf_inv(inv_affine(a)) : affine(gf_inv(a));

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: forward key schedule to round key 10, then
// ten inverse rounds, one per clock, walking the key schedule backwards.
//   AES_clk / AES_rst      : clock, asynchronous active-high reset
//   AES_en                 : start request, sampled only in IDLE
//   AES_data_in/AES_key_in : ciphertext and cipher key, captured on accept
//   AES_busy               : high from accept until the valid edge
//   AES_data_out           : plaintext, held until the next completion
//   AES_data_out_valid     : one-cycle pulse when AES_data_out updates
module aes_decrypt_core
  import aes_dec_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic         AES_busy,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_out_q, data_out_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  // ---------------- key path ----------------
  logic [31:0]  w0, w1, w2, w3, rcon_w, sub_in, sub_out, f0;
  logic [127:0] key_fwd, key_inv;

  assign {w0, w1, w2, w3} = key_q;
  assign rcon_w = {rcon(cnt_q), 24'h0};

  // One SubWord serves both directions: the forward step rotates w3, the
  // inverse step rotates the recovered previous w3 (= w3 ^ w2).
  assign sub_in = (fsm_q == DEC) ? rot_word(w3 ^ w2) : rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox_dual u_sbox (.inv(1'b0), .a(sub_in[8*i +: 8]), .y(sub_out[8*i +: 8]));
  end

  assign f0      = w0 ^ sub_out ^ rcon_w;
  assign key_fwd = {f0, w1 ^ f0, w2 ^ w1 ^ f0, w3 ^ w2 ^ w1 ^ f0};
  assign key_inv = {w0 ^ sub_out ^ rcon_w, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  // ---------------- state path ----------------
  logic [127:0] isr, isb, ark, round_out;

  assign isr = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox_dual u_sbox (.inv(1'b1), .a(isr[8*i +: 8]), .y(isb[8*i +: 8]));
  end

  assign ark       = isb ^ key_inv;
  assign round_out = (cnt_q == 4'd1) ? ark : inv_mix_columns(ark);

  // ---------------- control ----------------
  always_comb begin
    // NOTE: every variable gets its hold/default value first, so no path through the case infers a latch.
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    key_d      = key_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    case (fsm_q)
      IDLE: begin
        if (AES_en) begin
          // state_q doubles as the ciphertext holder during KEYEXP.
          state_d = AES_data_in;
          key_d   = AES_key_in;
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
          fsm_d   = KEYEXP;
        end
      end
      KEYEXP: begin
        key_d = key_fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) begin
          state_d = state_q ^ key_fwd;
          cnt_d   = 4'(NR);
          fsm_d   = DEC;
        end
      end
      DEC: begin
        if (cnt_q != 4'd0) begin
          state_d = round_out;
          key_d   = key_inv;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          // The last round has landed in state_q; publish it.
          data_out_d = state_q;
          valid_d    = 1'b1;
          busy_d     = 1'b0;
          fsm_d      = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      fsm_q      <= IDLE;
      cnt_q      <= 4'd0;
      state_q    <= '0;
      key_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      key_q      <= key_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign AES_busy           = busy_q;
  assign AES_data_out       = data_out_q;
  assign AES_data_out_valid = valid_q;

endmodule
